// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : pipe_pkg                                                         |
// | Shared constants and types for the MINI-RISC elastic pipeline stages.      |
// | Contents: stage MODE selectors, skid FSM state type, default NOP payload.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package pipe_pkg;

  // Stage implementation selectors for the MODE parameter
  localparam int PIPE_PASS = 0;  // combinational pass-through
  localparam int PIPE_REG  = 1;  // single register, combinational in_ready
  localparam int PIPE_SKID = 2;  // 2-entry skid buffer, registered in_ready

  // Payload loaded on reset/flush (NOP encoding of the packed bundle)
  localparam int PIPE_NOP = 0;

  // Skid buffer occupancy states
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage
`default_nettype wire

// File: rtl/elastic_pipe_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : elastic_pipe_reg_if                                            |
// | One valid/ready/data channel between two pipeline stages.                  |
// | Ports (signals):                                                           |
// |   valid : beat valid (producer -> consumer)                                |
// |   ready : consumer can take the beat (consumer -> producer)                |
// |   data  : DATA_W payload (producer -> consumer)                            |
// | Modports: master = producer side, slave = consumer side.                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface elastic_pipe_reg_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sat_counter                                                      |
// | Saturating up-counter for performance statistics.                          |
// | Ports:                                                                     |
// |   clk   in  1      clock, rising edge                                      |
// |   reset in  1      asynchronous, active-high                               |
// |   inc   in  1      count this cycle                                        |
// |   clr   in  1      synchronous clear, wins over inc                        |
// |   cnt   out CNT_W  current count, sticks at all-ones                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/elastic_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : elastic_pipe_reg                                                 |
// | Valid/ready elastic pipeline stage with hazard-unit stall/flush, selectable|
// | as pass-through (MODE 0), single register (MODE 1) or 2-entry skid buffer  |
// | (MODE 2), plus a saturating bubble counter.                                |
// | Ports:                                                                     |
// |   clk        in   1       clock, rising edge                              |
// |   reset      in   1       asynchronous, active-high                       |
// |   stall      in   1       hold: no accept, no release, contents kept      |
// |   flush      in   1       synchronous squash of all held beats            |
// |   up         slave        upstream channel (in_valid/in_ready/in_data)    |
// |   dn         master       downstream channel (out_valid/out_ready/data)   |
// |   occupancy  out  2       beats held (always 0 in MODE 0)                 |
// |   clr_stats  in   1       synchronous clear of bubble_cnt                 |
// |   bubble_cnt out  CNT_W   cycles with out_ready & !out_valid & !stall     |
// | The interface instances must be built with the same DATA_W as this stage. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                MODE    = PIPE_SKID,
  parameter logic [DATA_W-1:0] FLUSH_D = DATA_W'(PIPE_NOP),
  parameter int                CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  elastic_pipe_reg_if.slave  up,
  elastic_pipe_reg_if.master dn,
  output logic [1:0]       occupancy,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] bubble_cnt
);

  if (MODE == PIPE_SKID) begin : g_skid
    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              rdy_q, rdy_d;
    logic              in_fire;
    logic              out_fire;

    always_comb begin
      // rdy_q mirrors (state_q != ST_TWO), so in_fire can never occur in TWO
      in_fire  = up.valid & rdy_q & ~stall & ~flush;
      out_fire = (state_q != ST_EMPTY) & dn.ready & ~stall & ~flush;
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      if (flush) begin
        state_d = ST_EMPTY;
        main_d  = FLUSH_D;
        skid_d  = FLUSH_D;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              state_d = ST_ONE;
              main_d  = up.data;
            end
          end
          ST_ONE: begin
            if (in_fire && out_fire) begin
              main_d = up.data;
            end else if (in_fire) begin
              state_d = ST_TWO;
              skid_d  = up.data;
            end else if (out_fire) begin
              state_d = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (out_fire) begin
              state_d = ST_ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
      // Ready for next cycle is decided from the next state, keeping
      // out_ready off the combinational in_ready path.
      rdy_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_EMPTY;
        main_q  <= FLUSH_D;
        skid_q  <= FLUSH_D;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        rdy_q   <= rdy_d;
      end
    end

    always_comb begin
      case (state_q)
        ST_ONE:  occupancy = 2'd1;
        ST_TWO:  occupancy = 2'd2;
        default: occupancy = 2'd0;
      endcase
    end

    assign up.ready = rdy_q & ~stall;
    assign dn.valid = (state_q != ST_EMPTY);
    assign dn.data  = main_q;
  end else if (MODE == PIPE_REG) begin : g_reg
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic              rdy;
    logic              in_fire;
    logic              out_fire;

    always_comb begin
      rdy      = (~valid_q | dn.ready) & ~stall;
      in_fire  = up.valid & rdy & ~flush;
      out_fire = valid_q & dn.ready & ~stall & ~flush;
      valid_d  = valid_q;
      main_d   = main_q;
      if (flush) begin
        valid_d = 1'b0;
        main_d  = FLUSH_D;
      end else if (in_fire) begin
        // covers both refill-on-drain and fill-when-empty
        valid_d = 1'b1;
        main_d  = up.data;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        main_q  <= FLUSH_D;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end

    assign up.ready  = rdy;
    assign dn.valid  = valid_q;
    assign dn.data   = main_q;
    assign occupancy = {1'b0, valid_q};
  end else if (MODE == PIPE_PASS) begin : g_pass
    assign up.ready  = dn.ready & ~stall;
    assign dn.valid  = up.valid & ~flush;
    assign dn.data   = up.data;
    assign occupancy = 2'd0;
  end else begin : g_bad_mode
    $error("elastic_pipe_reg: illegal MODE %0d", MODE);
  end

  logic bubble_inc;
  assign bubble_inc = dn.ready & ~dn.valid & ~stall;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_inc),
    .clr   (clr_stats),
    .cnt   (bubble_cnt)
  );

endmodule
`default_nettype wire
